id_stage: RTL

- Decode stage that consumes the fetch stage's pc/instruction pair and produces a registered ID/EX pipeline bundle.
- Holds the 32x32 register file, which the writeback stage writes through a dedicated port.
- Generates RV32I immediates and control signals for the execute stage.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/id_stage.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage -- RV32I decode stage with integrated 32 x XLEN register file.
//
// Purpose:
//   Takes the fetch stage's pc/instruction pair, reads the register file,
//   generates the sign-extended immediate and the execute-stage control
//   signals, and registers everything into the ID/EX pipeline bundle.
//   The writeback stage writes the register file through its own port.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   pc_in, instr_in         fetch output (pc_in is instruction address + 4)
//   stall, flush            hazard-unit controls (see below)
//   wb_en, wb_rd, wb_data   register-file write port
//   valid_out ... illegal   registered ID/EX bundle
//
// Pipeline control: there is no valid/ready handshake here. Each rising edge
// the ID/EX register does exactly one of: flush (load a bubble, all zero),
// stall (hold every output), or load (capture the decoded instruction).
// flush wins over stall. The register-file write happens regardless.
//
// Configuration macro:
//   ID_WB_BYPASS_EN  when defined, a writeback to the register being read in
//                    the same cycle forwards wb_data into rs1_data/rs2_data.
//                    When undefined the old register value is captured and
//                    the hazard unit is expected to stall one cycle.
// ----------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            funct7_b5,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_src,
  output logic            branch,
  output logic            jump,
  output logic            lui,
  output logic            auipc,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } idex_t;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            wb_fire;

  // x0 is never written, so its storage stays at the reset value of zero.
  assign wb_fire = wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < NREGS);

  always_comb begin
    rf_d = rf_q;
    if (wb_fire) begin
      rf_d[wb_rd] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Register reads (combinational on the incoming instruction)
  // --------------------------------------------------------------------------
  logic [4:0]      src1_idx;
  logic [4:0]      src2_idx;
  logic [XLEN-1:0] src1_val;
  logic [XLEN-1:0] src2_val;

  assign src1_idx = instr_in[19:15];
  assign src2_idx = instr_in[24:20];

  always_comb begin
    src1_val = '0;
    src2_val = '0;
    if (src1_idx != 5'd0 && int'(src1_idx) < NREGS) begin
      src1_val = rf_q[src1_idx];
    end
    if (src2_idx != 5'd0 && int'(src2_idx) < NREGS) begin
      src2_val = rf_q[src2_idx];
    end
`ifdef ID_WB_BYPASS_EN
    // Forward the value being written this edge so no stall is needed.
    if (wb_fire && wb_rd == src1_idx) begin
      src1_val = wb_data;
    end
    if (wb_fire && wb_rd == src2_idx) begin
      src2_val = wb_data;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm32;
  idex_t       dec;

  assign opcode = instr_in[6:0];
  assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                   instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u  = {instr_in[31:12], 12'b0};
  assign imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                   instr_in[20], instr_in[30:21], 1'b0};

  always_comb begin
    dec           = '0;
    imm32         = '0;
    dec.valid     = 1'b1;
    dec.pc        = pc_in - XLEN'(4);
    dec.rs1       = src1_idx;
    dec.rs2       = src2_idx;
    dec.rd        = instr_in[11:7];
    dec.funct3    = instr_in[14:12];
    dec.funct7_b5 = instr_in[30];
    dec.rs1_data  = src1_val;
    dec.rs2_data  = src2_val;

    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm32         = imm_i;
      end
      OPC_LOAD: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
        imm32         = imm_i;
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.rd        = 5'd0;
        imm32         = imm_s;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.rd     = 5'd0;
        imm32      = imm_b;
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = imm_j;
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm32         = imm_i;
      end
      OPC_LUI: begin
        dec.lui       = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = imm_u;
      end
      OPC_AUIPC: begin
        dec.auipc     = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = imm_u;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    dec.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

    // Writes to x0 are architecturally discarded; don't ask for one.
    if (dec.rd == 5'd0) begin
      dec.reg_write = 1'b0;
    end

    // All-zero word is fetch's reset value: treat it as a bubble, not illegal.
    if (instr_in == 32'h0000_0000) begin
      dec.valid     = 1'b0;
      dec.illegal   = 1'b0;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.alu_src   = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.lui       = 1'b0;
      dec.auipc     = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // ID/EX register: flush > stall > load
  // --------------------------------------------------------------------------
  idex_t idex_q;
  idex_t idex_d;

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (!stall) begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign valid_out = idex_q.valid;
  assign pc_out    = idex_q.pc;
  assign rs1_data  = idex_q.rs1_data;
  assign rs2_data  = idex_q.rs2_data;
  assign imm       = idex_q.imm;
  assign rs1       = idex_q.rs1;
  assign rs2       = idex_q.rs2;
  assign rd        = idex_q.rd;
  assign funct3    = idex_q.funct3;
  assign funct7_b5 = idex_q.funct7_b5;
  assign reg_write = idex_q.reg_write;
  assign mem_read  = idex_q.mem_read;
  assign mem_write = idex_q.mem_write;
  assign alu_src   = idex_q.alu_src;
  assign branch    = idex_q.branch;
  assign jump      = idex_q.jump;
  assign lui       = idex_q.lui;
  assign auipc     = idex_q.auipc;
  assign illegal   = idex_q.illegal;

endmodule
